// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit stability filter for raw board switches.
// Define SWITCH_EDGE_IRQ_EN to build the rise/fall pulses and the sticky change irq.
module switch_debouncer #(
   parameter int WIDTH         = 8,
   parameter int STABLE_CYCLES = 50000,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] switch,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             irq,
   input  logic             irq_clr
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] db_nxt;
   logic [WIDTH-1:0] sw_q;
   logic [CNT_W-1:0] cnt     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_raw;
         s2 <= s1;
      end
   end

   // Any sample agreeing with the committed level abandons the pending change.
   always_comb begin
      // NOTE: defaults first, so every path assigns every bit and no latch is inferred.
      db_nxt = db;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (s2[i] != db[i]) begin
            if (cnt[i] == CNT_LAST) begin
               db_nxt[i] = s2[i];
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db <= '0;
         // NOTE: the counter array is real state that must restart on reset, so it is cleared element-wise.
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         db  <= db_nxt;
         cnt <= cnt_nxt;
      end
   end

   // The visible level trails db by one cycle so it lines up with the registered edge pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_q <= '0;
      end else begin
         sw_q <= db;
      end
   end

   assign switch = sw_q;

`ifdef SWITCH_EDGE_IRQ_EN
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   logic             irq_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_q <= '0;
         fall_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         rise_q <= db & ~sw_q;
         fall_q <= ~db & sw_q;
         // A fresh edge overrides a clear requested in the same cycle.
         irq_q  <= (|(db ^ sw_q)) | (irq_q & ~irq_clr);
      end
   end

   assign sw_rise = rise_q;
   assign sw_fall = fall_q;
   assign irq     = irq_q;
`else
   logic unused_irq_clr;

   assign unused_irq_clr = irq_clr;
   assign sw_rise        = '0;
   assign sw_fall        = '0;
   assign irq            = 1'b0;
`endif

endmodule
